clock_timekeeper: RTL and testbench

//  Parametrised successor to the 1 Hz hh:mm:ss counter. Runs from the system clock with an internal

---
 rtl/clock_timekeeper_if.sv | 25 ++
 rtl/clock_timekeeper.sv | 204 ++++++++++++++++++++
 tb/tb_clock_timekeeper.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_timekeeper_if.sv
// Set-time handshake bundle between a controller (master) and the timekeeper (slave).
// set_time packs {hour[16:12], min[11:6], sec[5:0]} in binary.
interface clock_timekeeper_if;
    logic        set_valid;
    logic        set_ready;
    logic [16:0] set_time;
    logic        set_done;
    logic        set_err;

    modport master (
        output set_valid,
        output set_time,
        input  set_ready,
        input  set_done,
        input  set_err
    );

    modport slave (
        input  set_valid,
        input  set_time,
        output set_ready,
        output set_done,
        output set_err
    );
endinterface

// File: rtl/clock_timekeeper.sv
// hh:mm:ss timekeeper driven from the system clock through a seconds prescaler.
// Validated time load over a ready/valid port, 12/24 h BCD display digits,
// NUM_ALARMS hh:mm alarm comparators, and sec/day ticks for downstream blocks.
module clock_timekeeper #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int NUM_ALARMS    = 2,
    localparam int AW           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  mode_12h,
    clock_timekeeper_if.slave     set_if,
    input  logic                  alarm_we,
    input  logic [AW-1:0]         alarm_idx,
    input  logic [10:0]           alarm_time,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] alarm_hit,
    output logic                  sec_tick,
    output logic                  day_tick,
    output logic [4:0]            hour_out,
    output logic                  pm,
    output logic [3:0]            sec_1s,
    output logic [3:0]            sec_10s,
    output logic [3:0]            min_1s,
    output logic [3:0]            min_10s,
    output logic [3:0]            hr_1s,
    output logic [3:0]            hr_10s
);

    localparam int CW = $clog2(TICKS_PER_SEC);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [4:0]            r_hour;
    logic [5:0]            r_min;
    logic [5:0]            r_sec;
    logic [16:0]           r_cap;
    logic                  r_sec_tick;
    logic                  r_day_tick;
    logic                  r_set_done;
    logic                  r_set_err;
    logic [NUM_ALARMS-1:0] r_alarm_hit;
    logic [10:0]           r_alarm [NUM_ALARMS];

    logic                  w_tick;
    logic [4:0]            w_nhour;
    logic [5:0]            w_nmin;
    logic [5:0]            w_nsec;
    logic                  w_day;
    logic [NUM_ALARMS-1:0] w_hit;
    logic [4:0]            w_hdisp;
    logic [7:0]            w_hr_bcd;
    logic [7:0]            w_min_bcd;
    logic [7:0]            w_sec_bcd;

    // Binary 0..63 to two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return {t[3:0], 4'(v - t * 6'd10)};
    endfunction

    // The prescaler only advances while the set FSM is idle, so a load never eats or duplicates a tick.
    assign w_tick = run && (r_state == S_IDLE) && (r_cnt == CW'(TICKS_PER_SEC - 1));

    // Next-second time value and alarm matches against that value.
    always_comb begin
        w_nsec  = r_sec;
        w_nmin  = r_min;
        w_nhour = r_hour;
        w_day   = 1'b0;
        if (r_sec == 6'd59) begin
            w_nsec = 6'd0;
            if (r_min == 6'd59) begin
                w_nmin = 6'd0;
                if (r_hour == 5'd23) begin
                    w_nhour = 5'd0;
                    w_day   = 1'b1;
                end else begin
                    w_nhour = r_hour + 5'd1;
                end
            end else begin
                w_nmin = r_min + 6'd1;
            end
        end else begin
            w_nsec = r_sec + 6'd1;
        end
        // Out-of-range stored alarms can never equal a legal time, so they simply never match.
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_hit[i] = alarm_en[i] && (r_alarm[i][10:6] == w_nhour) &&
                       (r_alarm[i][5:0] == w_nmin) && (w_nsec == 6'd0);
        end
    end

    // Set FSM, prescaler, time registers and all registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hour      <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_cap       <= '0;
            r_sec_tick  <= 1'b0;
            r_day_tick  <= 1'b0;
            r_set_done  <= 1'b0;
            r_set_err   <= 1'b0;
            r_alarm_hit <= '0;
        end else begin
            r_sec_tick  <= 1'b0;
            r_day_tick  <= 1'b0;
            r_set_done  <= 1'b0;
            r_set_err   <= 1'b0;
            r_alarm_hit <= '0;

            if (w_tick) begin
                r_cnt       <= '0;
                r_sec       <= w_nsec;
                r_min       <= w_nmin;
                r_hour      <= w_nhour;
                r_sec_tick  <= 1'b1;
                r_day_tick  <= w_day;
                r_alarm_hit <= w_hit;
            end else if (run && (r_state == S_IDLE)) begin
                r_cnt <= r_cnt + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (set_if.set_valid) begin
                        r_cap   <= set_if.set_time;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((r_cap[16:12] > 5'd23) || (r_cap[11:6] > 6'd59) || (r_cap[5:0] > 6'd59)) begin
                        r_set_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // Alarm pulses are only ever raised by a tick, never by a load.
                    r_hour     <= r_cap[16:12];
                    r_min      <= r_cap[11:6];
                    r_sec      <= r_cap[5:0];
                    r_cnt      <= '0;
                    r_set_done <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Alarm slot storage; writes to non-existent slots are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_alarm[i] <= '0;
            end
        end else if (alarm_we && (int'(alarm_idx) < NUM_ALARMS)) begin
            r_alarm[alarm_idx] <= alarm_time;
        end
    end

    // Display hour: 0 shows as 12, 13..23 fold down by 12 in 12 h mode.
    always_comb begin
        w_hdisp = r_hour;
        if (mode_12h) begin
            if (r_hour == 5'd0) begin
                w_hdisp = 5'd12;
            end else if (r_hour > 5'd12) begin
                w_hdisp = r_hour - 5'd12;
            end
        end
    end

    assign w_hr_bcd  = to_bcd({1'b0, w_hdisp});
    assign w_min_bcd = to_bcd(r_min);
    assign w_sec_bcd = to_bcd(r_sec);

    assign hr_10s  = w_hr_bcd[7:4];
    assign hr_1s   = w_hr_bcd[3:0];
    assign min_10s = w_min_bcd[7:4];
    assign min_1s  = w_min_bcd[3:0];
    assign sec_10s = w_sec_bcd[7:4];
    assign sec_1s  = w_sec_bcd[3:0];

    assign hour_out  = r_hour;
    assign pm        = (r_hour >= 5'd12);
    assign sec_tick  = r_sec_tick;
    assign day_tick  = r_day_tick;
    assign alarm_hit = r_alarm_hit;

    assign set_if.set_ready = (r_state == S_IDLE);
    assign set_if.set_done  = r_set_done;
    assign set_if.set_err   = r_set_err;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper with TICKS_PER_SEC=4, NUM_ALARMS=2.
module tb_clock_timekeeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       alarm_we = 1'b0;
    logic [0:0] alarm_idx = 1'b0;
    logic [10:0] alarm_time = '0;
    logic [1:0] alarm_en = '0;
    logic [1:0] alarm_hit;
    logic       sec_tick, day_tick, pm;
    logic [4:0] hour_out;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;

    int checks = 0;
    int errors = 0;

    clock_timekeeper_if sif ();

    clock_timekeeper #(.TICKS_PER_SEC(4), .NUM_ALARMS(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode_12h(mode_12h),
        .set_if(sif),
        .alarm_we(alarm_we), .alarm_idx(alarm_idx), .alarm_time(alarm_time),
        .alarm_en(alarm_en), .alarm_hit(alarm_hit),
        .sec_tick(sec_tick), .day_tick(day_tick), .hour_out(hour_out), .pm(pm),
        .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
        .hr_1s(hr_1s), .hr_10s(hr_10s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          h, m, s;
        logic        m12;
        logic        err;
        logic [23:0] dig;
        logic        pm;
        logic [4:0]  hout;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] digits();
        return {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int h, input int m, input int s,
                        output logic err2, output logic rdy2, output logic done3, output logic err3);
        sif.set_time  = {5'(h), 6'(m), 6'(s)};
        sif.set_valid = 1'b1;
        step();
        sif.set_valid = 1'b0;
        step();
        err2 = sif.set_err;
        rdy2 = sif.set_ready;
        step();
        done3 = sif.set_done;
        err3  = sif.set_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic e2, r2, d3, e3;
        logic [1:0] en_list [4];

        sif.set_valid = 1'b0;
        sif.set_time  = '0;

        vt[0]  = '{12, 34, 56, 1'b0, 1'b0, 24'h123456, 1'b1, 5'd12};
        vt[1]  = '{12, 34, 56, 1'b1, 1'b0, 24'h123456, 1'b1, 5'd12};
        vt[2]  = '{ 0, 30,  0, 1'b1, 1'b0, 24'h123000, 1'b0, 5'd0};
        vt[3]  = '{13,  5,  0, 1'b1, 1'b0, 24'h010500, 1'b1, 5'd13};
        vt[4]  = '{13,  5,  0, 1'b0, 1'b0, 24'h130500, 1'b1, 5'd13};
        vt[5]  = '{24,  0,  0, 1'b0, 1'b1, 24'h130500, 1'b1, 5'd13};
        vt[6]  = '{10, 60,  0, 1'b0, 1'b1, 24'h130500, 1'b1, 5'd13};
        vt[7]  = '{10,  0, 60, 1'b0, 1'b1, 24'h130500, 1'b1, 5'd13};
        vt[8]  = '{23, 59, 59, 1'b1, 1'b0, 24'h115959, 1'b1, 5'd23};
        vt[9]  = '{11,  7,  9, 1'b1, 1'b0, 24'h110709, 1'b0, 5'd11};
        vt[10] = '{31, 63, 63, 1'b1, 1'b1, 24'h110709, 1'b0, 5'd11};
        vt[11] = '{ 1,  0,  0, 1'b1, 1'b0, 24'h010000, 1'b0, 5'd1};
        vt[12] = '{ 0,  0,  0, 1'b0, 1'b0, 24'h000000, 1'b0, 5'd0};

        // Reset state, then free-running count
        run = 1'b1;
        step();
        chk("rst digits", digits(), 24'h000000);
        chk("rst ready", sif.set_ready, 1);
        chk("rst done", sif.set_done, 0);
        chk("rst sec_tick", sec_tick, 0);
        chk("rst day_tick", day_tick, 0);
        chk("rst alarm_hit", alarm_hit, 0);
        chk("rst hour_out", hour_out, 0);
        mode_12h = 1'b1;
        #1;
        chk("rst digits 12h", digits(), 24'h120000);
        mode_12h = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("run sec_tick c%0d", k), sec_tick, (k % 4 == 0) ? 1 : 0);
        end
        chk("run time", digits(), 24'h000003);
        run = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("frozen sec_tick", sec_tick, 0);
        end
        chk("frozen time", digits(), 24'h000003);

        // Table-driven loads with prescaler frozen
        for (int i = 0; i < 13; i++) begin
            mode_12h = vt[i].m12;
            load(vt[i].h, vt[i].m, vt[i].s, e2, r2, d3, e3);
            if (vt[i].err) begin
                chk($sformatf("v%0d set_err", i), e2, 1);
                chk($sformatf("v%0d ready after reject", i), r2, 1);
                chk($sformatf("v%0d no set_done", i), d3, 0);
                chk($sformatf("v%0d set_err width", i), e3, 0);
            end else begin
                chk($sformatf("v%0d no set_err", i), e2, 0);
                chk($sformatf("v%0d set_done", i), d3, 1);
            end
            chk($sformatf("v%0d digits", i), digits(), vt[i].dig);
            chk($sformatf("v%0d pm", i), pm, vt[i].pm);
            chk($sformatf("v%0d hour_out", i), hour_out, vt[i].hout);
        end

        // Midnight wrap
        mode_12h = 1'b0;
        load(23, 59, 58, e2, r2, d3, e3);
        chk("wrap load done", d3, 1);
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 4) begin
                chk("wrap 23:59:59", digits(), 24'h235959);
                chk("wrap early day_tick", day_tick, 0);
            end
            if (k == 8) begin
                chk("wrap 00:00:00", digits(), 24'h000000);
                chk("wrap day_tick", day_tick, 1);
                chk("wrap sec_tick", sec_tick, 1);
                chk("wrap hour_out", hour_out, 0);
            end
        end
        step();
        chk("wrap day_tick width", day_tick, 0);
        run = 1'b0;

        // Alarms
        alarm_we = 1'b1;
        alarm_idx = 1'b0;
        alarm_time = {5'd7, 6'd0};
        step();
        alarm_idx = 1'b1;
        step();
        alarm_we = 1'b0;
        alarm_en = 2'b11;
        load(7, 0, 0, e2, r2, d3, e3);
        chk("commit on alarm done", d3, 1);
        chk("commit raises no alarm", alarm_hit, 0);

        en_list[0] = 2'b01;
        en_list[1] = 2'b00;
        en_list[2] = 2'b11;
        en_list[3] = 2'b10;
        run = 1'b1;
        for (int j = 0; j < 4; j++) begin
            alarm_en = en_list[j];
            load(6, 59, 59, e2, r2, d3, e3);
            for (int k = 1; k <= 3; k++) begin
                step();
                chk($sformatf("alarm%0d hold c%0d", j, k), sec_tick, 0);
            end
            step();
            chk($sformatf("alarm%0d sec_tick", j), sec_tick, 1);
            chk($sformatf("alarm%0d hit", j), alarm_hit, en_list[j]);
            chk($sformatf("alarm%0d time", j), digits(), 24'h070000);
            step();
            chk($sformatf("alarm%0d hit width", j), alarm_hit, 0);
        end
        run = 1'b0;

        // Reset while the set FSM is in CHECK
        sif.set_time  = {5'd12, 6'd0, 6'd0};
        sif.set_valid = 1'b1;
        step();
        chk("mid-set ready low", sif.set_ready, 0);
        sif.set_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-set rst digits", digits(), 24'h000000);
        chk("mid-set rst ready", sif.set_ready, 1);
        chk("mid-set rst done", sif.set_done, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post-rst no done", sif.set_done, 0);
        end
        chk("post-rst digits", digits(), 24'h000000);
        chk("post-rst ready", sif.set_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
